truth_table_sequencer: RTL and testbench

//  Self-running exhaustive test controller for a 4-input, 2-pair combinational

---
 rtl/truth_table_sequencer.sv | 101 ++++++++++
 tb/tb_truth_table_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: exhaustive sweep of an N_IN-input vector, comparing N_PAIR output pairs per vector.
// Optional TTSEQ_STOP_ON_ERR_EN ends the run at the first mismatching vector.
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_PAIR = 2,
  parameter int DWELL  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2*N_PAIR-1:0]   dut_f_i,
  output logic [N_IN-1:0]       vec_out_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [N_IN:0]         err_count_o,
  output logic [N_IN-1:0]       first_err_vec_o,
  output logic                  first_err_vld_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [N_IN-1:0] VMAX = '1;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_q, vec_d, fev_q, fev_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fvld_q, fvld_d, pass_q, pass_d;
  logic              mis, fin, settled;
  always_comb begin
    mis = 1'b0;
    for (int k = 0; k < N_PAIR; k++) mis = mis | (dut_f_i[2*k+1] ^ dut_f_i[2*k]);
  end
`ifdef TTSEQ_STOP_ON_ERR_EN
  assign fin = (vec_q == VMAX) || mis;
`else
  assign fin = (vec_q == VMAX);
`endif
  assign settled = (cnt_q == CW'(DWELL - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      fev_q   <= '0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      fev_q   <= fev_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      pass_q  <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? SETTLE : IDLE;
      SETTLE:  state_d = abort_i ? FINISH : (settled ? CHECK : SETTLE);
      CHECK:   state_d = (abort_i || fin) ? FINISH : SETTLE;
      default: state_d = IDLE;
    endcase
  end
  // abort in CHECK suppresses that vector's compare entirely
  always_comb begin
    cnt_d  = (state_q == SETTLE) ? cnt_q + 1'b1 : '0;
    vec_d  = vec_q;
    fev_d  = fev_q;
    err_d  = err_q;
    fvld_d = fvld_q;
    pass_d = pass_q;
    if (state_q == IDLE && start_i) begin
      vec_d  = '0;
      fev_d  = '0;
      err_d  = '0;
      fvld_d = 1'b0;
      pass_d = 1'b0;
    end else if (state_q == CHECK && !abort_i) begin
      err_d  = mis ? err_q + 1'b1 : err_q;
      fev_d  = (mis && !fvld_q) ? vec_q : fev_q;
      fvld_d = fvld_q | mis;
      vec_d  = fin ? vec_q : vec_q + 1'b1;
      pass_d = fin && !mis && (err_q == '0);
    end else if ((state_q == SETTLE || state_q == CHECK) && abort_i) begin
      pass_d = 1'b0;
    end
  end
  always_comb begin
    busy_o          = (state_q != IDLE);
    done_o          = (state_q == FINISH);
    pass_o          = pass_q;
    vec_out_o       = vec_q;
    err_count_o     = err_q;
    first_err_vec_o = fev_q;
    first_err_vld_o = fvld_q;
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed checks of sweep timing, error capture, abort, reset and start handling.
module tb_truth_table_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [3:0]  dut_f_i, vec_out_o, first_err_vec_o;
  logic [4:0]  err_count_o;
  logic        busy_o, done_o, pass_o, first_err_vld_o;
  logic [15:0] flip11 = '0, flip22 = '0;
  logic        f1, f2, seq_ok;
  int          errors = 0, checks = 0, cyc;
  truth_table_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .dut_f_i(dut_f_i),
    .vec_out_o(vec_out_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_vec_o(first_err_vec_o), .first_err_vld_o(first_err_vld_o)
  );
  always #5 clk = ~clk;
  assign f1 = vec_out_o[3] ^ vec_out_o[2];
  assign f2 = vec_out_o[1] & vec_out_o[0];
  assign dut_f_i = {f1, f1 ^ flip11[vec_out_o], f2, f2 ^ flip22[vec_out_o]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // accepts a start, then counts cycles until done; start/abort can be pulsed at given cycles
  task automatic run(input bit hold, input int s1, input int s2, input int ab);
    start_i = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    seq_ok = (vec_out_o == 4'd0) && busy_o;
    start_i = hold || cyc == s1 || cyc == s2;
    abort_i = (cyc == ab);
    while (!done_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!done_o && (vec_out_o !== 4'(cyc / 3) || !busy_o)) seq_ok = 1'b0;
      start_i = hold || cyc == s1 || cyc == s2;
      abort_i = (cyc == ab);
    end
    start_i = hold;
    abort_i = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_pass", pass_o, 0);
    chk("rst_vec", vec_out_o, 0);
    chk("rst_err", err_count_o, 0);
    chk("rst_fvld", first_err_vld_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, -1, -1, -1);
    chk("clean_done_cyc", cyc, 48);
    chk("clean_seq", seq_ok, 1);
    chk("clean_pass", pass_o, 1);
    chk("clean_err", err_count_o, 0);
    chk("clean_fvld", first_err_vld_o, 0);
    chk("clean_vec", vec_out_o, 15);
    chk("clean_busy_fin", busy_o, 1);
    @(posedge clk); #1;
    chk("clean_idle_busy", busy_o, 0);
    chk("clean_idle_done", done_o, 0);
    chk("clean_hold_vec", vec_out_o, 15);
    chk("clean_hold_pass", pass_o, 1);
    flip11[5] = 1'b1; flip22[5] = 1'b1; flip22[12] = 1'b1;
    run(0, -1, -1, -1);
`ifdef TTSEQ_STOP_ON_ERR_EN
    chk("stop_done_cyc", cyc, 18);
    chk("stop_vec", vec_out_o, 5);
    chk("stop_err", err_count_o, 1);
`else
    chk("err_done_cyc", cyc, 48);
    chk("err_count", err_count_o, 2);
`endif
    chk("err_fvec", first_err_vec_o, 5);
    chk("err_fvld", first_err_vld_o, 1);
    chk("err_pass", pass_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_hold_fvec", first_err_vec_o, 5);
    flip11 = '0; flip22 = '0;
    run(0, -1, -1, 10);
    chk("abort_done_cyc", cyc, 11);
    chk("abort_pass", pass_o, 0);
    chk("abort_err", err_count_o, 0);
    @(posedge clk); #1;
    chk("abort_busy_after", busy_o, 0);
    run(0, -1, -1, -1);
    chk("rerun_done_cyc", cyc, 48);
    chk("rerun_pass", pass_o, 1);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_busy_pre", busy_o, 1);
    chk("midrst_vec_pre", vec_out_o, 6);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_vec", vec_out_o, 0);
    chk("midrst_done", done_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(0, -1, -1, -1);
    chk("postrst_done_cyc", cyc, 48);
    @(posedge clk); #1;
    run(0, 5, 30, -1);
    chk("ignore_start_cyc", cyc, 48);
    chk("ignore_start_seq", seq_ok, 1);
    @(posedge clk); #1;
    run(1, -1, -1, -1);
    chk("b2b_first_cyc", cyc, 48);
    @(posedge clk); #1;
    chk("b2b_idle_busy", busy_o, 0);
    run(1, -1, -1, -1);
    chk("b2b_second_cyc", cyc, 48);
    chk("b2b_second_pass", pass_o, 1);
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_stop_busy", busy_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
